// File: rtl/draw_pkg.sv
// draw_pkg: shared types and helpers for the sprite draw engine
package draw_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  localparam int DEF_KEY = 0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/draw_pixel_pipe.sv
// draw_pixel_pipe: delays pixel valid/clip/position to line up with the sprite ROM read data
module draw_pixel_pipe #(
  parameter int DEPTH = 2,
  parameter int X_W = 9,
  parameter int Y_W = 8
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_v,
  input  logic           i_clip,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  output logic           o_v,
  output logic           o_clip,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y
);
  localparam int PW = X_W + Y_W + 2;
  logic [PW-1:0] r_q [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    else begin
      r_q[0] <= {i_v, i_clip, i_x, i_y};
      for (int i = 1; i < DEPTH; i++) r_q[i] <= r_q[i-1];
    end
  assign {o_v, o_clip, o_x, o_y} = r_q[DEPTH-1];
endmodule

// File: rtl/draw_sprite_engine.sv
// draw_sprite_engine: row-major sprite blitter with mirroring, colour-key transparency and clipping
module draw_sprite_engine
  import draw_pkg::*;
#(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COLOR_W = 12,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ROM_LATENCY = 1,
  parameter int TRANSPARENT_EN = 1,
  parameter logic [COLOR_W-1:0] KEY = COLOR_W'(DEF_KEY),
  parameter int COUNT_W = 3,
  localparam int N = SPRITE_W * SPRITE_H,
  localparam int ADDR_W = (clog2(N) < 1) ? 1 : clog2(N)
)(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x_init,
  input  logic [Y_W-1:0]     y_init,
  input  logic               mirror_x,
  input  logic               count_clr,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_q,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [X_W-1:0]     X_out,
  output logic [Y_W-1:0]     Y_out,
  output logic [COLOR_W-1:0] Color_out,
  output logic [COUNT_W-1:0] sprite_count
);
  localparam int CW = (clog2(SPRITE_W) < 1) ? 1 : clog2(SPRITE_W);
  localparam int RW = (clog2(SPRITE_H) < 1) ? 1 : clog2(SPRITE_H);
  localparam int DW = (clog2(ROM_LATENCY + 1) < 1) ? 1 : clog2(ROM_LATENCY + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic [X_W-1:0] r_x0, w_x0, w_px, r_x;
  logic [Y_W-1:0] r_y0, w_y0, w_py, r_y;
  logic r_mir, w_mir, r_plot;
  logic [DW-1:0] r_dcnt;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [X_W:0] w_xs;
  logic [Y_W:0] w_ys;
  logic [COLOR_W-1:0] r_color;
  logic [COUNT_W-1:0] r_count;
  logic w_go, w_eol, w_last, w_issue, w_clip, w_pv, w_pclip, w_show;
  // the issue side looks one pixel ahead: at each edge it registers the address of the pixel presented next
  assign w_go = r_state == IDLE && start;
  assign w_eol = r_col == CW'(SPRITE_W - 1);
  assign w_last = r_state == SCAN && w_eol && r_row == RW'(SPRITE_H - 1);
  assign w_issue = w_go || (r_state == SCAN && !w_last);
  assign w_col = (w_go || w_eol) ? '0 : r_col + CW'(1);
  assign w_row = w_go ? '0 : w_eol ? r_row + RW'(1) : r_row;
  assign w_x0 = w_go ? x_init : r_x0;
  assign w_y0 = w_go ? y_init : r_y0;
  assign w_mir = w_go ? mirror_x : r_mir;
  assign w_xs = (X_W+1)'(w_x0) + (X_W+1)'(w_col);
  assign w_ys = (Y_W+1)'(w_y0) + (Y_W+1)'(w_row);
  assign w_clip = w_xs >= (X_W+1)'(SCREEN_W) || w_ys >= (Y_W+1)'(SCREEN_H);
  assign w_addr = ADDR_W'(w_row * SPRITE_W) + ADDR_W'(w_mir ? CW'(SPRITE_W - 1) - w_col : w_col);
  assign w_show = w_pv && !w_pclip && !(TRANSPARENT_EN != 0 && rom_q == KEY);
  draw_pixel_pipe #(.DEPTH(ROM_LATENCY + 1), .X_W(X_W), .Y_W(Y_W)) u_pipe (
    .clk(clk), .rst(resetn),
    .i_v(w_issue), .i_clip(w_clip), .i_x(w_xs[X_W-1:0]), .i_y(w_ys[Y_W-1:0]),
    .o_v(w_pv), .o_clip(w_pclip), .o_x(w_px), .o_y(w_py)
  );
  always_ff @(posedge clk or posedge resetn)
    if (resetn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_go) w_next = SCAN;
    else if (w_last) w_next = DRAIN;
    else if (r_state == DRAIN && r_dcnt == DW'(ROM_LATENCY)) w_next = DONE;
    else if (r_state == DONE) w_next = IDLE;
  end
  always_comb begin
    busy = r_state != IDLE;
    done = r_state == DONE;
  end
  always_ff @(posedge clk or posedge resetn)
    if (resetn) begin
      r_col <= '0;
      r_row <= '0;
      r_addr <= '0;
      r_x0 <= '0;
      r_y0 <= '0;
      r_mir <= 1'b0;
      r_dcnt <= '0;
      r_count <= '0;
      r_plot <= 1'b0;
      r_x <= '0;
      r_y <= '0;
      r_color <= '0;
    end else begin
      if (w_issue) begin
        r_col <= w_col;
        r_row <= w_row;
        r_addr <= w_addr;
      end
      if (w_go) begin
        r_x0 <= x_init;
        r_y0 <= y_init;
        r_mir <= mirror_x;
      end
      r_dcnt <= (r_state == DRAIN) ? r_dcnt + DW'(1) : '0;
      r_count <= count_clr ? '0 : r_count + COUNT_W'(r_state == DONE);
      r_plot <= w_show;
      if (w_show) begin
        r_x <= w_px;
        r_y <= w_py;
        r_color <= rom_q;
      end
    end
  assign rom_addr = r_addr;
  assign plot = r_plot;
  assign X_out = r_x;
  assign Y_out = r_y;
  assign Color_out = r_color;
  assign sprite_count = r_count;
endmodule

// File: tb/tb_draw_sprite_engine.sv
// tb_draw_sprite_engine: randomized and directed checks of the sprite engine against a pixel-list model
module tb_draw_sprite_engine;
  localparam int W = 16, H = 16, N = 256, L = 1, P = N + L + 3;
  typedef struct {int c; int x; int y; int col;} px_t;
  logic clk = 0, resetn = 1, start = 0, mirror_x = 0, count_clr = 0, start2 = 0;
  logic [8:0] x_init = 0;
  logic [7:0] y_init = 0;
  logic [7:0] rom_addr, addr2;
  logic [11:0] rom_q, q2a, q2, Color_out, C2;
  logic busy, done, plot, busy2, done2, plot2;
  logic [8:0] X_out, X2;
  logic [7:0] Y_out, Y2;
  logic [2:0] sprite_count, cnt2;
  logic [11:0] rom [N];
  logic [11:0] rom2 [200];
  int cyc = 0, vectors = 0, miscompares = 0, exp_count = 0, base = 0, hold_bad = 0;
  int p2_n = 0, p2_first = -1, p2_col = -1, d2_cyc = -1;
  px_t got[$], exp_q[$];
  int done_cyc[$];
  bit hv = 0;
  int lx, ly, lc;

  draw_sprite_engine dut (
    .clk(clk), .resetn(resetn), .start(start), .x_init(x_init), .y_init(y_init),
    .mirror_x(mirror_x), .count_clr(count_clr), .rom_addr(rom_addr), .rom_q(rom_q),
    .busy(busy), .done(done), .plot(plot), .X_out(X_out), .Y_out(Y_out),
    .Color_out(Color_out), .sprite_count(sprite_count)
  );
  draw_sprite_engine #(.SPRITE_W(20), .SPRITE_H(10), .ROM_LATENCY(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .x_init(9'd0), .y_init(8'd0),
    .mirror_x(1'b0), .count_clr(1'b0), .rom_addr(addr2), .rom_q(q2),
    .busy(busy2), .done(done2), .plot(plot2), .X_out(X2), .Y_out(Y2),
    .Color_out(C2), .sprite_count(cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rom_q <= rom[rom_addr];
  always @(posedge clk) begin
    q2a <= rom2[addr2];
    q2 <= q2a;
  end

  always @(negedge clk) begin
    if (resetn) hv = 0;
    else if (plot) begin
      got.push_back('{cyc, int'(X_out), int'(Y_out), int'(Color_out)});
      lx = X_out; ly = Y_out; lc = Color_out; hv = 1;
    end else if (hv && (X_out != 9'(lx) || Y_out != 8'(ly) || Color_out != 12'(lc))) hold_bad++;
    if (done) done_cyc.push_back(cyc);
    if (plot2) begin
      if (p2_n == 0) begin p2_first = cyc; p2_col = C2; end
      p2_n++;
    end
    if (done2) d2_cyc = cyc;
  end

  // reference: every pixel the sprite should put on screen, with the cycle it must appear in
  task automatic add_exp(input int x0, input int y0, input bit mir, input int b);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int a, x, y, col;
        a = r * W + (mir ? W - 1 - c : c);
        col = rom[a]; x = x0 + c; y = y0 + r;
        if (x < 320 && y < 240 && col != 0) exp_q.push_back('{b + r * W + c + 2 + L, x, y, col});
      end
  endtask

  task automatic start_draw(input int x0, input int y0, input bit mir, input bit hold, input int ndraw);
    @(negedge clk);
    x_init = 9'(x0); y_init = 8'(y0); mirror_x = mir; start = 1; base = cyc;
    got.delete(); done_cyc.delete(); exp_q.delete(); hold_bad = 0;
    for (int i = 0; i < ndraw; i++) add_exp(x0, y0, mir, base + i * P);
    @(negedge clk);
    start = hold;
  endtask

  task automatic finish_draw(input string nm, input int ndraw, input bit scramble, input bit clr);
    int t, nd, bad;
    t = 0; nd = 0; bad = -1;
    while (nd < ndraw && t < 1000 * ndraw) begin
      @(negedge clk);
      t++;
      if (scramble) begin x_init = 9'($urandom); y_init = 8'($urandom); mirror_x = 1'($urandom); end
      if (done) begin
        nd++;
        if (nd == ndraw) begin start = 0; count_clr = clr; end
      end
    end
    @(negedge clk);
    count_clr = 0;
    repeat (3) @(negedge clk);
    exp_count = clr ? 0 : (exp_count + ndraw) % 8;
    vectors++;
    if (nd != ndraw) begin miscompares++; $display("FAIL %s timeout: %0d of %0d done pulses", nm, nd, ndraw); end
    for (int i = 0; i < ndraw; i++) begin
      vectors++;
      if (i >= done_cyc.size() || done_cyc[i] != base + i * P + N + 2 + L) begin
        miscompares++;
        $display("FAIL %s done[%0d] cycle: got %0d want %0d", nm, i,
                 (i < done_cyc.size()) ? done_cyc[i] - base : -1, i * P + N + 2 + L);
      end
    end
    vectors++;
    if (got.size() != exp_q.size()) begin
      miscompares++; $display("FAIL %s plot count: got %0d want %0d", nm, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size() && bad < 0; i++)
      if (got[i].c != exp_q[i].c || got[i].x != exp_q[i].x || got[i].y != exp_q[i].y || got[i].col != exp_q[i].col) bad = i;
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s pixel %0d: got cyc %0d (%0d,%0d) col %0d, want cyc %0d (%0d,%0d) col %0d", nm, bad,
               got[bad].c - base, got[bad].x, got[bad].y, got[bad].col,
               exp_q[bad].c - base, exp_q[bad].x, exp_q[bad].y, exp_q[bad].col);
    end
    vectors++;
    if (hold_bad != 0) begin miscompares++; $display("FAIL %s output hold: %0d cycles changed without plot, want 0", nm, hold_bad); end
    vectors++;
    if (sprite_count !== 3'(exp_count)) begin
      miscompares++; $display("FAIL %s sprite_count: got %0d want %0d", nm, sprite_count, exp_count);
    end
  endtask

  task automatic do_reset();
    resetn = 1;
    repeat (2) @(negedge clk);
    resetn = 0;
    exp_count = 0;
  endtask

  task automatic fill_inc();
    for (int i = 0; i < N; i++) rom[i] = 12'(i + 1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({plot, busy, done} !== 3'b000) begin miscompares++; $display("FAIL reset flags: got %b want 000", {plot, busy, done}); end
    vectors++;
    if (sprite_count !== 3'd0) begin miscompares++; $display("FAIL reset count: got %0d want 0", sprite_count); end
    vectors++;
    if (rom_addr !== 8'd0) begin miscompares++; $display("FAIL reset rom_addr: got %0d want 0", rom_addr); end
    vectors++;
    if ({X_out, Y_out, Color_out} !== 29'd0) begin
      miscompares++; $display("FAIL reset pixel outs: got %0d,%0d,%0d want 0", X_out, Y_out, Color_out);
    end
    resetn = 0;
  endtask

  task automatic test_basic();
    fill_inc();
    start_draw(10, 20, 0, 0, 1);
    finish_draw("basic", 1, 0, 0);
    vectors++;
    if (got.size() != 256 || got[0].c - base != 3 || got[0].x != 10 || got[0].y != 20 || got[0].col != 1) begin
      miscompares++; $display("FAIL basic first plot: got n=%0d cyc %0d (%0d,%0d) col %0d want n=256 cyc 3 (10,20) col 1",
                              got.size(), got.size() ? got[0].c - base : -1, got.size() ? got[0].x : -1,
                              got.size() ? got[0].y : -1, got.size() ? got[0].col : -1);
    end
    vectors++;
    if (got.size() == 0 || got[$].x != 25 || got[$].y != 35 || got[$].col != 256) begin
      miscompares++; $display("FAIL basic last plot: got (%0d,%0d) col %0d want (25,35) col 256",
                              got.size() ? got[$].x : -1, got.size() ? got[$].y : -1, got.size() ? got[$].col : -1);
    end
  endtask

  task automatic test_transparency();
    bit seen;
    fill_inc();
    rom[5] = 0;
    start_draw(10, 20, 0, 0, 1);
    finish_draw("transparency", 1, 0, 0);
    seen = 0;
    foreach (got[i]) if (got[i].x == 15 && got[i].y == 20) seen = 1;
    vectors++;
    if (seen || got.size() != 255) begin
      miscompares++; $display("FAIL transparency key pixel: got seen=%0d n=%0d want seen=0 n=255", seen, got.size());
    end
  endtask

  task automatic test_clipping();
    fill_inc();
    start_draw(310, 20, 0, 0, 1);
    finish_draw("clip_x", 1, 0, 0);
    vectors++;
    if (got.size() != 160) begin miscompares++; $display("FAIL clip_x count: got %0d want 160", got.size()); end
    start_draw(10, 230, 0, 0, 1);
    finish_draw("clip_y", 1, 0, 0);
    vectors++;
    if (got.size() != 160) begin miscompares++; $display("FAIL clip_y count: got %0d want 160", got.size()); end
  endtask

  task automatic test_mirror();
    int bad;
    fill_inc();
    bad = -1;
    start_draw(10, 20, 1, 0, 1);
    for (int k = 0; k < 32; k++) begin
      if (bad < 0 && int'(rom_addr) != ((k < 16) ? 15 - k : 47 - k)) bad = k;
      @(negedge clk);
    end
    vectors++;
    if (bad >= 0) begin miscompares++; $display("FAIL mirror rom_addr sequence: first wrong at pixel %0d", bad); end
    finish_draw("mirror", 1, 0, 0);
    vectors++;
    if (got.size() == 0 || got[0].x != 10 || got[0].y != 20 || got[0].col != 16) begin
      miscompares++; $display("FAIL mirror first plot: got (%0d,%0d) col %0d want (10,20) col 16",
                              got.size() ? got[0].x : -1, got.size() ? got[0].y : -1, got.size() ? got[0].col : -1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N; i++) rom[i] = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom);
      start_draw($urandom_range(0, 330), $urandom_range(0, 250), 1'($urandom), 0, 1);
      finish_draw("random", 1, 1, 0);
    end
  endtask

  task automatic test_handshake();
    fill_inc();
    start_draw(40, 50, 0, 1, 1);
    finish_draw("handshake", 1, 0, 0);
    repeat (20) @(negedge clk);
    vectors++;
    if (done_cyc.size() != 1 || busy !== 1'b0 || got.size() != 256) begin
      miscompares++; $display("FAIL handshake single draw: got dones=%0d busy=%b plots=%0d want 1,0,256",
                              done_cyc.size(), busy, got.size());
    end
  endtask

  task automatic test_back_to_back();
    start_draw(100, 100, 1, 1, 2);
    finish_draw("back_to_back", 2, 0, 0);
  endtask

  task automatic test_reset_mid();
    start_draw(0, 0, 0, 0, 1);
    repeat (99) @(negedge clk);
    resetn = 1;
    #1;
    vectors++;
    if ({plot, busy, done} !== 3'b000 || sprite_count !== 3'd0) begin
      miscompares++; $display("FAIL mid reset: got plot=%b busy=%b done=%b count=%0d want all 0", plot, busy, done, sprite_count);
    end
    repeat (3) @(negedge clk);
    resetn = 0;
    exp_count = 0;
    got.delete(); done_cyc.delete();
    repeat (300) @(negedge clk);
    vectors++;
    if (got.size() != 0 || done_cyc.size() != 0) begin
      miscompares++; $display("FAIL after reset: got %0d plots %0d dones want 0 0", got.size(), done_cyc.size());
    end
    start_draw($urandom_range(0, 330), $urandom_range(0, 250), 1'($urandom), 0, 1);
    finish_draw("post_reset", 1, 0, 0);
  endtask

  task automatic test_count_wrap();
    do_reset();
    start_draw(200, 200, 0, 1, 8);
    finish_draw("wrap8", 8, 0, 0);
    vectors++;
    if (sprite_count !== 3'd0) begin miscompares++; $display("FAIL wrap count: got %0d want 0", sprite_count); end
    start_draw(5, 5, 0, 0, 1);
    finish_draw("clr_done", 1, 0, 1);
    vectors++;
    if (sprite_count !== 3'd0) begin miscompares++; $display("FAIL count_clr at done: got %0d want 0", sprite_count); end
  endtask

  task automatic test_params();
    int b2, t;
    for (int i = 0; i < 200; i++) rom2[i] = 12'(i + 7);
    @(negedge clk);
    start2 = 1; b2 = cyc; p2_n = 0; d2_cyc = -1;
    @(negedge clk);
    start2 = 0;
    t = 0;
    while (d2_cyc < 0 && t < 1000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    vectors++;
    if (p2_first - b2 != 4 || p2_col != 7) begin
      miscompares++; $display("FAIL params first plot: got cyc %0d col %0d want cyc 4 col 7", p2_first - b2, p2_col);
    end
    vectors++;
    if (d2_cyc - b2 != 204) begin miscompares++; $display("FAIL params done cycle: got %0d want 204", d2_cyc - b2); end
    vectors++;
    if (p2_n != 200 || cnt2 !== 3'd1) begin
      miscompares++; $display("FAIL params plots/count: got %0d/%0d want 200/1", p2_n, cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_transparency();
    test_clipping();
    test_mirror();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
